uart_tx_scheduler: RTL
======================

// Module: uart_tx_scheduler
// PURPOSE
//  Shares the single UART transmitter between three requesters: command acks, alarm bytes and the periodic
//  7-byte stats report. Sits between stats/uart command decode and the UART serializer in the tamagotchi top.
//  Queues one request per source, grants by fixed priority, and hands the serializer one byte per handshake.
//  Report packets are never split.
// PARAMETERS
//  ALARM_LEVEL  5'd3  a stat at or below this value raises its alarm flag
//  REPORT_DIV   4'd1  a report is queued every REPORT_DIV 'second' pulses (0 behaves as 1)
//  START_WAIT   4'd8  cycles to wait for tx_busy to rise after tx_start before treating the byte as sent
// PORTS
//  clk           in   1  system clock, single domain
//  reset         in   1  synchronous, active-high
//  second        in   1  one-cycle 1 Hz tick
//  ack_req       in   1  one-cycle pulse: send ack_data
//  ack_data      in   8  ack byte, sampled when ack_req=1
//  hunger,happiness,health,hygiene,energy  in  5 each  current pet stats
//  is_sleeping   in   1  pet asleep
//  status        in   8  status register
//  tx_busy       in   1  serializer busy
//  tx_start      out  1  one-cycle pulse: load tx_data into serializer
//  tx_data       out  8  byte to send, valid while tx_start=1
//  busy          out  1  scheduler not in IDLE
//  report_active out  1  a report packet is in flight
//  ack_overflow  out  1  sticky: an ack was overwritten before being sent
// BEHAVIOUR
//  Reset: all outputs 0, all pendings cleared, report divider 0, prev alarm flags 0, FSM -> IDLE.
//  Reset mid-byte/mid-packet aborts immediately; no further tx_start is issued.
//  Pending latches (set takes priority over a same-cycle clear):
//   ack: set on ack_req; byte latched. ack_req while pending -> byte overwritten, ack_overflow<=1.
//   report: divider counts 'second'; on reaching REPORT_DIV it wraps to 0 and report_pend<=1.
//     A tick while a report is in flight queues exactly one more report; further ticks merge.
//   alarm: flags[4:0]={energy,hygiene,health,happiness,hunger}<=ALARM_LEVEL.
//     Registered once per cycle. alarm_pend<=1 when flags!=0, flags!=prev_flags and !is_sleeping.
//     Alarm byte = {3'b110,flags}, captured at grant.
//  FSM states: IDLE, START, WAIT_HI, WAIT_LO.
//   IDLE: grant by priority ack > alarm > report, then -> START; nothing pending -> stay.
//     Report grant snapshots the 5 stats, status and is_sleeping into the packet buffer and sets idx=0.
//     Report grant sets report_active=1.
//   START: tx_start=1 for exactly one cycle with tx_data; -> WAIT_HI.
//   WAIT_HI: tx_busy=1 -> WAIT_LO. If START_WAIT cycles pass without it -> byte done.
//   WAIT_LO: tx_busy=0 -> byte done.
//   Byte done: for a report with idx<6, idx++ and -> START (no re-arbitration). Otherwise clear the
//     served pending and report_active, and -> IDLE.
//  Report packet (7 bytes, stats zero-extended to 8 bits):
//   8'hA5 (awake) or 8'hA4 (asleep), hunger, happiness, health, hygiene, energy, status.
//  Minimum gap: 1 IDLE cycle between granted messages. tx_start never asserts while tx_busy=1 in START.
//   If tx_busy=1 on entering START, hold in START until it drops, then pulse.
//  busy=1 in every state except IDLE.
// STRUCTURE
//  tama_pkg.vh: state encodings; REPORT_HDR_AWAKE=8'hA5, REPORT_HDR_SLEEP=8'hA4; ALARM_TAG=3'b110.
//  Sub-module alarm_detect: threshold compare, prev-flags register, change/suppress logic;
//   outputs alarm_set and flags.
//  Pending latches, divider, snapshot buffer and FSM stay in uart_tx_scheduler.
// TESTING
//  1 report: REPORT_DIV=1; stats 10,11,12,13,14, status=8'h3C, awake; pulse second; model busy 20 cycles/byte
//    -> bytes A5,0A,0B,0C,0D,0E,3C, 7 tx_start pulses.
//  2 priority/no-preempt: ack_req(8'h55) in cycle 2 of a report -> 55 follows 3C, never interleaved.
//    ack+alarm pending together -> ack first.
//  3 alarm: health 20->2 awake -> one byte 8'hC4. Health stays 2 -> no repeat.
//    Then energy 2 -> 8'hD4. While asleep: no alarm bytes.
//  4 overflow: two ack_req (11, 22) while busy -> only 22 sent, ack_overflow=1 until reset.
//  5 timeout: tx_busy tied 0 -> each byte advances after START_WAIT=8 cycles; a full report completes.
//  6 reset mid-packet at byte 3 -> tx_start=0, busy=0 next cycle; nothing sent until next second.
//  Checkers: tx_start is one-cycle, never while tx_busy=1; snapshot is stable when stats change mid-packet.

Source files
------------

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and constants for the UART transmit scheduler.
//   state_t : scheduler FSM states
//   src_t   : which requester owns the message currently in flight
//   report packet header bytes, alarm byte tag, packet length
//   stat_low: threshold compare used by the alarm detector
package uart_tx_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_HI,
    ST_WAIT_LO
  } state_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ACK,
    SRC_ALARM,
    SRC_REPORT
  } src_t;

  localparam logic [7:0] REPORT_HDR_AWAKE = 8'hA5;
  localparam logic [7:0] REPORT_HDR_SLEEP = 8'hA4;
  localparam logic [2:0] ALARM_TAG        = 3'b110;
  localparam logic [2:0] REPORT_LAST_IDX  = 3'd6;

  function automatic logic stat_low(input logic [4:0] stat, input logic [4:0] level);
    return (stat <= level);
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_alarm_detect.sv
// Alarm detector: registers per-stat low flags every cycle and reports a
// one-cycle alarm_set when the flag set is non-empty, differs from the
// previous cycle's set, and the pet is awake.
//   i_clk, i_reset        : clock, synchronous active-high reset
//   i_hunger..i_energy    : current pet stats
//   i_is_sleeping         : suppresses alarm_set while asleep
//   o_alarm_set           : request to queue an alarm byte
//   o_flags               : {energy,hygiene,health,happiness,hunger} low flags
module uart_tx_scheduler_alarm_detect
  import uart_tx_scheduler_pkg::*;
#(
  parameter logic [4:0] ALARM_LEVEL = 5'd3
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [4:0] i_hunger,
  input  logic [4:0] i_happiness,
  input  logic [4:0] i_health,
  input  logic [4:0] i_hygiene,
  input  logic [4:0] i_energy,
  input  logic       i_is_sleeping,
  output logic       o_alarm_set,
  output logic [4:0] o_flags
);

  logic [4:0] w_flags_now;
  logic [4:0] r_flags;
  logic [4:0] r_prev_flags;

  assign w_flags_now = {stat_low(i_energy,    ALARM_LEVEL),
                        stat_low(i_hygiene,   ALARM_LEVEL),
                        stat_low(i_health,    ALARM_LEVEL),
                        stat_low(i_happiness, ALARM_LEVEL),
                        stat_low(i_hunger,    ALARM_LEVEL)};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_flags      <= '0;
      r_prev_flags <= '0;
    end else begin
      r_flags      <= w_flags_now;
      r_prev_flags <= r_flags;
    end
  end

  // prev_flags tracks even while asleep, so waking up with an unchanged
  // flag set does not replay a stale alarm.
  assign o_alarm_set = (r_flags != '0) && (r_flags != r_prev_flags) && !i_is_sleeping;
  assign o_flags     = r_flags;

endmodule

// File: rtl/uart_tx_scheduler.sv
// UART transmit scheduler: shares one serializer between command acks,
// alarm bytes and the periodic 7-byte stats report. One pending slot per
// source, fixed priority ack > alarm > report, reports never split.
//   i_clk, i_reset       : clock, synchronous active-high reset
//   i_second             : 1 Hz tick driving the report divider
//   i_ack_req/i_ack_data : ack byte request
//   i_hunger..i_energy   : pet stats (report payload, alarm source)
//   i_is_sleeping        : report header select, alarm suppress
//   i_status             : last report byte
//   i_tx_busy            : serializer busy
//   o_tx_start/o_tx_data : one-cycle load strobe and byte to serializer
//   o_busy               : FSM not idle
//   o_report_active      : report packet in flight
//   o_ack_overflow       : sticky, an unsent ack was overwritten
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter logic [4:0] ALARM_LEVEL = 5'd3,
  parameter logic [3:0] REPORT_DIV  = 4'd1,
  parameter logic [3:0] START_WAIT  = 4'd8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_second,
  input  logic       i_ack_req,
  input  logic [7:0] i_ack_data,
  input  logic [4:0] i_hunger,
  input  logic [4:0] i_happiness,
  input  logic [4:0] i_health,
  input  logic [4:0] i_hygiene,
  input  logic [4:0] i_energy,
  input  logic       i_is_sleeping,
  input  logic [7:0] i_status,
  input  logic       i_tx_busy,
  output logic       o_tx_start,
  output logic [7:0] o_tx_data,
  output logic       o_busy,
  output logic       o_report_active,
  output logic       o_ack_overflow
);

  state_t     r_state, w_state_next;
  src_t       r_src;
  logic       r_ack_pend, r_alarm_pend, r_report_pend, r_report_again;
  logic [7:0] r_ack_byte, r_tx_byte;
  logic [7:0] r_pkt [0:6];
  logic [2:0] r_idx;
  logic [3:0] r_div, r_wait_cnt;
  logic       r_report_active, r_ack_overflow;

  logic       w_alarm_set;
  logic [4:0] w_flags;
  logic [3:0] w_div_eff;
  logic       w_report_tick, w_wait_expired, w_more;
  logic       w_tx_start, w_byte_done, w_last_done;
  logic       w_grant_ack, w_grant_alarm, w_grant_report;
  logic       w_report_busy;

  uart_tx_scheduler_alarm_detect #(
    .ALARM_LEVEL(ALARM_LEVEL)
  ) u_alarm (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_hunger     (i_hunger),
    .i_happiness  (i_happiness),
    .i_health     (i_health),
    .i_hygiene    (i_hygiene),
    .i_energy     (i_energy),
    .i_is_sleeping(i_is_sleeping),
    .o_alarm_set  (w_alarm_set),
    .o_flags      (w_flags)
  );

  assign w_div_eff      = (REPORT_DIV == 4'd0) ? 4'd1 : REPORT_DIV;
  assign w_report_tick  = i_second && (({1'b0, r_div} + 5'd1) >= {1'b0, w_div_eff});
  assign w_wait_expired = ({1'b0, r_wait_cnt} + 5'd1) >= {1'b0, START_WAIT};
  assign w_more         = (r_src == SRC_REPORT) && (r_idx < REPORT_LAST_IDX);
  assign w_last_done    = w_byte_done && !w_more;
  // A report granted this cycle counts as in flight for tick queueing.
  assign w_report_busy  = r_report_active || w_grant_report;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next   = r_state;
    w_tx_start     = 1'b0;
    w_byte_done    = 1'b0;
    w_grant_ack    = 1'b0;
    w_grant_alarm  = 1'b0;
    w_grant_report = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (r_ack_pend) begin
          w_grant_ack  = 1'b1;
          w_state_next = ST_START;
        end else if (r_alarm_pend) begin
          w_grant_alarm = 1'b1;
          w_state_next  = ST_START;
        end else if (r_report_pend) begin
          w_grant_report = 1'b1;
          w_state_next   = ST_START;
        end
      end
      ST_START: begin
        if (!i_tx_busy) begin
          w_tx_start   = 1'b1;
          w_state_next = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        if (i_tx_busy)           w_state_next = ST_WAIT_LO;
        else if (w_wait_expired) w_byte_done  = 1'b1;
      end
      ST_WAIT_LO: begin
        if (!i_tx_busy) w_byte_done = 1'b1;
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (w_byte_done) w_state_next = w_more ? ST_START : ST_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_src           <= SRC_NONE;
      r_ack_pend      <= 1'b0;
      r_alarm_pend    <= 1'b0;
      r_report_pend   <= 1'b0;
      r_report_again  <= 1'b0;
      r_ack_byte      <= '0;
      r_tx_byte       <= '0;
      r_idx           <= '0;
      r_div           <= '0;
      r_wait_cnt      <= '0;
      r_report_active <= 1'b0;
      r_ack_overflow  <= 1'b0;
      for (int unsigned i = 0; i < 7; i++) r_pkt[i] <= '0;
    end else begin
      if (i_second) r_div <= w_report_tick ? 4'd0 : r_div + 4'd1;

      if (i_ack_req) begin
        r_ack_byte <= i_ack_data;
        r_ack_pend <= 1'b1;
        if (r_ack_pend) r_ack_overflow <= 1'b1;
      end else if (w_last_done && r_src == SRC_ACK) begin
        r_ack_pend <= 1'b0;
      end

      if (w_alarm_set)                                r_alarm_pend <= 1'b1;
      else if (w_last_done && r_src == SRC_ALARM)     r_alarm_pend <= 1'b0;

      // r_report_again holds the single report queued behind the one in
      // flight; it becomes the new pending bit when that packet ends.
      if (w_last_done && r_src == SRC_REPORT) begin
        r_report_pend  <= r_report_again || w_report_tick;
        r_report_again <= 1'b0;
      end else if (w_report_tick) begin
        if (w_report_busy) r_report_again <= 1'b1;
        else               r_report_pend  <= 1'b1;
      end

      if (w_grant_ack) begin
        r_src     <= SRC_ACK;
        r_tx_byte <= r_ack_byte;
      end
      if (w_grant_alarm) begin
        r_src     <= SRC_ALARM;
        r_tx_byte <= {ALARM_TAG, w_flags};
      end
      if (w_grant_report) begin
        r_src           <= SRC_REPORT;
        r_idx           <= '0;
        r_report_active <= 1'b1;
        r_tx_byte       <= i_is_sleeping ? REPORT_HDR_SLEEP : REPORT_HDR_AWAKE;
        r_pkt[0]        <= i_is_sleeping ? REPORT_HDR_SLEEP : REPORT_HDR_AWAKE;
        r_pkt[1]        <= {3'b000, i_hunger};
        r_pkt[2]        <= {3'b000, i_happiness};
        r_pkt[3]        <= {3'b000, i_health};
        r_pkt[4]        <= {3'b000, i_hygiene};
        r_pkt[5]        <= {3'b000, i_energy};
        r_pkt[6]        <= i_status;
      end

      if (w_byte_done && w_more) begin
        r_idx     <= r_idx + 3'd1;
        r_tx_byte <= r_pkt[r_idx + 3'd1];
      end
      if (w_last_done) begin
        r_src           <= SRC_NONE;
        r_report_active <= 1'b0;
      end

      if (w_tx_start)                 r_wait_cnt <= '0;
      else if (r_state == ST_WAIT_HI) r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

  assign o_tx_start      = w_tx_start;
  assign o_tx_data       = r_tx_byte;
  assign o_busy          = (r_state != ST_IDLE);
  assign o_report_active = r_report_active;
  assign o_ack_overflow  = r_ack_overflow;

endmodule
